// File: rtl/sonar_ranger.sv
// sonar_ranger: fires an ultrasonic TRIG pulse, times the ECHO high width in clocks, reports result/timeout.
module sonar_ranger #(
    parameter int WIDTH          = 32,
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1900000,
    parameter int HOLDOFF_CYCLES = 3000000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             echo,
    output logic             trig,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             timeout,
    output logic [WIDTH-1:0] echo_cycles
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] TRIG      = 3'd1;
    localparam logic [2:0] WAIT_RISE = 3'd2;
    localparam logic [2:0] MEASURE   = 3'd3;
    localparam logic [2:0] HOLDOFF   = 3'd4;

    localparam logic [WIDTH-1:0] TRIG_LAST = WIDTH'(TRIG_CYCLES - 1);
    localparam logic [WIDTH-1:0] HOLD_LAST = WIDTH'(HOLDOFF_CYCLES - 1);
    localparam logic [WIDTH-1:0] TMO_LAST  = WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] TMO_MAX   = WIDTH'(TIMEOUT_CYCLES);

    logic [2:0]       state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] tcount;
    logic [WIDTH-1:0] width;
    logic             echo_m;
    logic             echo_s;
    logic             echo_d;
    logic             rise;
    logic             fall;
    logic             expire;

    assign rise   = echo_s & ~echo_d;
    assign fall   = ~echo_s & echo_d;
    // A fall while measuring beats a coincident timeout; in WAIT_RISE a fall is meaningless.
    assign expire = (state == WAIT_RISE || state == MEASURE) && tcount == TMO_LAST && !(state == MEASURE && fall);
    assign trig   = state == TRIG;
    assign busy   = state != IDLE;

    // Two-flop synchronizer for the raw ECHO pin, plus one stage for edge detection.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            {echo_m, echo_s, echo_d} <= 3'b000;
        end else begin
            {echo_m, echo_s, echo_d} <= {echo, echo_m, echo_s};
        end
    end

    // Ping sequencer: trigger, wait for echo, measure width, then enforce dead time.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            tcount      <= '0;
            width       <= '0;
            done        <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            echo_cycles <= '0;
        end else begin
            done <= expire | (state == MEASURE & fall);
            if (expire) begin
                timeout     <= 1'b1;
                echo_cycles <= '1;
                tcount      <= TMO_MAX;
                count       <= '0;
                state       <= HOLDOFF;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            valid       <= 1'b0;
                            timeout     <= 1'b0;
                            echo_cycles <= '0;
                            count       <= '0;
                            state       <= TRIG;
                        end
                    end
                    TRIG: begin
                        count  <= count == TRIG_LAST ? '0 : count + 1'b1;
                        tcount <= '0;
                        state  <= count == TRIG_LAST ? WAIT_RISE : TRIG;
                    end
                    WAIT_RISE: begin
                        tcount <= tcount + 1'b1;
                        if (rise) begin
                            width <= WIDTH'(1);
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        tcount <= tcount + 1'b1;
                        if (fall) begin
                            echo_cycles <= width;
                            valid       <= 1'b1;
                            count       <= '0;
                            state       <= HOLDOFF;
                        end else if (echo_s && width != '1) begin
                            width <= width + 1'b1;
                        end
                    end
                    HOLDOFF: begin
                        count <= count + 1'b1;
                        state <= count == HOLD_LAST ? IDLE : HOLDOFF;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sonar_ranger.sv
// tb_sonar_ranger: random and directed pings scored against a pin-timing model of the ranger.
module tb_sonar_ranger;
    localparam int W  = 32;
    localparam int TC = 4;
    localparam int TO = 100;
    localparam int HO = 20;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic         echo = 1'b0;
    logic         trig;
    logic         busy;
    logic         done;
    logic         valid;
    logic         timeout;
    logic [W-1:0] echo_cycles;

    sonar_ranger #(.WIDTH(W), .TRIG_CYCLES(TC), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .echo(echo),
        .trig(trig), .busy(busy), .done(done), .valid(valid),
        .timeout(timeout), .echo_cycles(echo_cycles)
    );

    typedef struct {
        logic         ok;
        logic         tmo;
        logic [W-1:0] cycles;
        int           at;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_at = -1;
    int   trig_run = 0;
    logic busy_q = 1'b0;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: trig width, done results from the scoreboard, and holdoff length.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            trig_run = 0;
            done_at  = -1;
        end else begin
            if (trig) trig_run++;
            else if (trig_run > 0) begin
                chk("trig_width", trig_run, TC);
                trig_run = 0;
            end
            if (done) begin
                chk("done_expected", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("done_time", cyc, e.at);
                    chk("valid", valid, e.ok);
                    chk("timeout", timeout, e.tmo);
                    chk("echo_cycles", echo_cycles, e.cycles);
                end
                done_at = cyc;
            end
            if (busy_q === 1'b1 && busy === 1'b0 && done_at >= 0) begin
                chk("holdoff", cyc - done_at, HO);
                done_at = -1;
            end
        end
        busy_q = busy;
    end

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin
            @(negedge clock);
            k++;
        end
        chk("idle_wait", busy, 0);
    endtask

    task automatic fire(output int f);
        int k = 0;
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
        chk("trig_first", trig, 1);
        chk("result_cleared", {valid, timeout, echo_cycles}, 0);
        while (trig && k < 50) begin
            @(negedge clock);
            k++;
        end
        chk("trig_fall", trig, 0);
        f = cyc;
    endtask

    // d: cycles after trig fall that echo rises; n: echo high cycles (0 = none).
    task automatic ping(input int d, input int n, input bit stuck, input bit poke);
        int   f;
        exp_t e;
        logic seen;
        wait_idle(400);
        if (stuck) begin
            @(posedge clock);
            #1 echo = 1'b1;
        end
        fire(f);
        if (stuck || n == 0 || d + n + 3 > TO) begin
            e.ok = 1'b0; e.tmo = 1'b1; e.cycles = '1; e.at = f + TO;
        end else begin
            e.ok = 1'b1; e.tmo = 1'b0; e.cycles = W'(n); e.at = f + d + n + 3;
        end
        sbq.push_back(e);
        if (!stuck && n > 0) begin
            repeat (d) @(posedge clock);
            #1 echo = 1'b1;
            for (int i = 1; i <= n; i++) begin
                @(posedge clock);
                #1 start = poke && i == n / 2;
            end
            echo  = 1'b0;
            start = 1'b0;
        end
        if (poke) begin
            while (cyc < e.at + 5) @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_idle(TO + HO + 200);
        echo = 1'b0;
        if (poke) begin
            seen = 1'b0;
            repeat (8) begin
                @(negedge clock);
                seen |= busy | trig;
            end
            chk("start_not_queued", seen, 0);
        end
    endtask

    initial begin
        int   f;
        int   d;
        int   n;
        int   k;
        logic seen;
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        start = 1'b0;
        @(negedge clock);
        chk("rst_trig", trig, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_echo_cycles", echo_cycles, 0);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            seen |= trig | busy;
        end
        chk("idle_quiet", seen, 0);

        ping(10, 37, 1'b0, 1'b0);
        ping(10, 0, 1'b0, 1'b0);
        ping(10, 87, 1'b0, 1'b0);
        ping(10, 88, 1'b0, 1'b0);
        ping(0, 0, 1'b1, 1'b0);
        ping(10, 37, 1'b0, 1'b1);

        wait_idle(400);
        fire(f);
        repeat (2) @(posedge clock);
        #1 echo = 1'b1;
        repeat (10) @(posedge clock);
        #1 reset_n = 1'b0;
        echo = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_trig", trig, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_echo_cycles", echo_cycles, 0);
        ping(5, 15, 1'b0, 1'b0);

        repeat (16) begin
            d = $urandom_range(1, 60);
            n = $urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 110);
            ping(d, n, 1'b0, n > 0 && d + n <= 80 && $urandom_range(0, 3) == 0);
        end

        k = 0;
        while (sbq.size() > 0 && k < 500) begin
            @(negedge clock);
            k++;
        end
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sonar_ranger.md
Name: sonar_ranger

Overview:
- Memory-mapped-side ranging engine that sits directly downstream of the processor's IO pins.
- The processor requests a ping. The block drives the ultrasonic TRIG pin, times the ECHO pulse width in clock cycles, and returns the result with status flags.
- It offloads microsecond-accurate pulse timing from software. It runs on the processor clock (the 50 MHz divided clock).

Parameters:
- WIDTH, 32: width of echo_cycles and the internal counters.
- TRIG_CYCLES, 500: TRIG high time in cycles (10 us at 50 MHz).
- TIMEOUT_CYCLES, 1900000: maximum cycles from TRIG fall to ECHO fall before abort (38 ms).
- HOLDOFF_CYCLES, 3000000: dead time after each ping before a new start is accepted (60 ms).

Ports:
- clock, in, 1: system clock; all logic on rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- start, in, 1: single-cycle request; sampled only in IDLE.
- echo, in, 1: raw asynchronous ECHO pin.
- trig, out, 1: TRIG pin drive.
- busy, out, 1: high in every state except IDLE.
- done, out, 1: one-cycle pulse at end of measurement (success or timeout).
- valid, out, 1: last result is a good measurement; held until next accepted start.
- timeout, out, 1: last ping aborted; held until next accepted start.
- echo_cycles, out, WIDTH: last measured ECHO high width in cycles; held.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset (reset_n=0 at an edge) forces:
  - trig=0, busy=0, done=0, valid=0, timeout=0, echo_cycles=0.
  - state=IDLE, all counters=0, sync flops=0.
  - Applies mid-ping too: trig falls at that edge.
- ECHO synchronizer: 2-flop chain to echo_s, plus a registered echo_d for edge detection.
  - rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
- IDLE: busy=0.
  - On start=1: clear valid, timeout, echo_cycles; go TRIG; counter=0.
- TRIG: trig=1 for exactly TRIG_CYCLES cycles.
  - The first trig=1 cycle is the cycle after the start edge.
  - Then trig=0, tcount=0, go WAIT_RISE.
- WAIT_RISE: tcount increments every cycle.
  - An ECHO already high on entry is ignored; only a rise counts.
  - On rise: width=1, go MEASURE.
- MEASURE: while echo_s=1, width increments (saturating at all-ones); tcount keeps incrementing.
  - On fall: echo_cycles<=width, valid<=1, done=1 for one cycle, go HOLDOFF.
- Timeout: in WAIT_RISE or MEASURE, when tcount reaches TIMEOUT_CYCLES and no fall occurs in that cycle:
  - timeout<=1, valid stays 0, echo_cycles<=all-ones, done=1, go HOLDOFF.
  - If fall and timeout coincide, fall wins (valid measurement).
- HOLDOFF: wait HOLDOFF_CYCLES cycles with busy=1, then go IDLE.
  - start is ignored in every non-IDLE state; it is not queued.
- Width rule: an ECHO synchronous to clock held high for exactly N cycles yields echo_cycles=N.
  - Result latency is 3 cycles after the raw falling edge (2 sync flops + edge register).
- Counters never wrap: width saturates; tcount stops at TIMEOUT_CYCLES.
- start arriving in the same cycle as reset_n=0: reset wins.

Test Plan (TRIG_CYCLES=4, TIMEOUT_CYCLES=100, HOLDOFF_CYCLES=20 unless stated):
- Reset then idle: reset_n=0 for 2 cycles, release -> all outputs 0; trig stays 0 for 50 cycles with no start.
- Normal ping: start pulse; echo rises 10 cycles after trig falls, held 37 cycles -> trig high exactly 4 cycles; done pulses once; echo_cycles=37, valid=1, timeout=0; busy falls 20 cycles after done.
- No echo: start, echo held 0 -> done 100 cycles after trig falls; timeout=1, valid=0, echo_cycles=0xFFFFFFFF.
- Stuck echo: echo=1 before start and never falls -> no measurement starts; timeout reported at tcount=100.
- Start while busy: second start during MEASURE and during HOLDOFF -> ignored; exactly one done; new ping only when start is asserted after busy=0.
- Reset mid-MEASURE: reset_n=0 while trig/echo active -> next edge: busy=0, valid=0, echo_cycles=0; a subsequent start with a 15-cycle echo gives echo_cycles=15.
